// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Brief    : Request/result bundle between the execute stage and ex_muldiv.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             md_stall;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, md_stall, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Multi-cycle MIPS-style HI/LO multiply/divide unit with MTHI/MTLO.
// Revision : 1.0
// ============================================================================
module ex_muldiv #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ex_muldiv_if.slave  bus
);
    localparam int C_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int C_CNT_W   = $clog2(C_MAX_LAT + 1);

    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_LAT - 1);
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_LAT - 1);

    localparam logic [2:0] C_OP_MULT  = 3'b001;
    localparam logic [2:0] C_OP_MULTU = 3'b010;
    localparam logic [2:0] C_OP_DIV   = 3'b011;
    localparam logic [2:0] C_OP_DIVU  = 3'b100;
    localparam logic [2:0] C_OP_MTHI  = 3'b101;
    localparam logic [2:0] C_OP_MTLO  = 3'b110;

    logic               r_busy;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;

    logic                      w_is_md;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0]        w_prod_u;
    logic                      w_sdiv;
    logic [WIDTH-1:0]          w_dvd;
    logic [WIDTH-1:0]          w_dvs;
    logic [WIDTH-1:0]          w_uq;
    logic [WIDTH-1:0]          w_ur;
    logic [WIDTH-1:0]          w_quot;
    logic [WIDTH-1:0]          w_rem;

    assign w_is_md = (bus.op == C_OP_MULT) || (bus.op == C_OP_MULTU) ||
                     (bus.op == C_OP_DIV)  || (bus.op == C_OP_DIVU);

    assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) *
                      $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide runs on magnitudes; most-negative / -1 then falls out
    // naturally as quotient = most-negative, remainder = 0.
    assign w_sdiv = (r_op == C_OP_DIV);
    assign w_dvd  = (w_sdiv && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_dvs  = (w_sdiv && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;
    assign w_uq   = (w_dvs != '0) ? (w_dvd / w_dvs) : '0;
    assign w_ur   = (w_dvs != '0) ? (w_dvd % w_dvs) : '0;
    assign w_quot = (w_sdiv && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? (~w_uq + 1'b1) : w_uq;
    assign w_rem  = (w_sdiv && r_a[WIDTH-1]) ? (~w_ur + 1'b1) : w_ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                case (r_op)
                    C_OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                    C_OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                    C_OP_DIV, C_OP_DIVU: begin
                        // Divide by zero burns the full latency but keeps HI/LO.
                        if (r_b != '0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                    default: ;
                endcase
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (bus.start) begin
            case (bus.op)
                C_OP_MULT, C_OP_MULTU: begin
                    r_a    <= bus.A;
                    r_b    <= bus.B;
                    r_op   <= bus.op;
                    r_busy <= 1'b1;
                    r_cnt  <= C_MULT_LOAD;
                end
                C_OP_DIV, C_OP_DIVU: begin
                    r_a    <= bus.A;
                    r_b    <= bus.B;
                    r_op   <= bus.op;
                    r_busy <= 1'b1;
                    r_cnt  <= C_DIV_LOAD;
                end
                C_OP_MTHI: r_hi <= bus.A;
                C_OP_MTLO: r_lo <= bus.A;
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.md_stall = r_busy | (bus.start & w_is_md);
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Directed scoreboard bench for ex_muldiv (WIDTH=32, 5/10 latency).
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv;
    localparam int         C_MLAT = 5;
    localparam int         C_DLAT = 10;
    localparam logic [2:0] OP_NONE0 = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NONE7 = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [63:0] sb[$];

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32), .MULT_LAT(C_MLAT), .DIV_LAT(C_DLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hilo"}, {bus.HI, bus.LO}, e);
        end
    endtask

    // Caller is mid-cycle with busy=0; request is accepted at the next edge.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp,
                          input bit intrude, output int acc);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        sb.push_back(exp);
        #1 chk({tag, "_stall_req"}, bus.md_stall, 1);
        @(posedge clk); #1;
        acc = cyc;
        for (int i = 0; i < lat; i++) begin
            bus.start = intrude;
            bus.op    = (i % 2 == 0) ? OP_MTLO : OP_DIV;
            bus.A     = intrude ? 32'hAAAAAAAA : $urandom;
            bus.B     = $urandom;
            #1;
            chk($sformatf("%s_busy%0d", tag, i + 1), bus.busy, 1);
            chk($sformatf("%s_stall%0d", tag, i + 1), bus.md_stall, 1);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        #1 chk({tag, "_busy_end"}, bus.busy, 0);
        pop_chk(tag);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [63:0] exp);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = 32'h0;
        sb.push_back(exp);
        #1 chk({tag, "_stall"}, bus.md_stall, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1 chk({tag, "_busy"}, bus.busy, 0);
        pop_chk(tag);
    endtask

    initial begin
        int a1, a2;
        // Reset asserted with a competing MTHI request: reset must win.
        reset = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'hFFFFFFFF; bus.B = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.md_stall, 0);
        chk("rst_hilo", {bus.HI, bus.LO}, 64'h0);

        run_md("mult",   OP_MULT,  32'hFFFFFFFF, 32'h00000002, C_MLAT, 64'hFFFFFFFF_FFFFFFFE, 0, a1);
        run_md("multu",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, C_MLAT, 64'h00000001_FFFFFFFE, 0, a1);
        run_md("div_neg", OP_DIV,  32'hFFFFFFF9, 32'h00000002, C_DLAT, 64'hFFFFFFFF_FFFFFFFD, 0, a1);
        run_md("divu",   OP_DIVU,  32'h00000007, 32'h00000002, C_DLAT, 64'h00000001_00000003, 0, a1);
        run_md("div_ovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, C_DLAT, 64'h00000000_80000000, 0, a1);
        run_mt("mthi",   OP_MTHI,  32'h12345678, 64'h12345678_80000000);
        run_md("divu_z", OP_DIVU,  32'h00000005, 32'h00000000, C_DLAT, 64'h12345678_80000000, 0, a1);
        run_mt("mtlo",   OP_MTLO,  32'h0BADF00D, 64'h12345678_0BADF00D);
        run_md("mult_intr", OP_MULT, 32'h00000003, 32'hFFFFFFFE, C_MLAT, 64'hFFFFFFFF_FFFFFFFA, 1, a1);

        // op 000 / 111 are no-ops and never stall.
        bus.start = 1'b1; bus.op = OP_NONE0; bus.A = 32'h55555555;
        #1 chk("nop0_stall", bus.md_stall, 0);
        @(posedge clk); #1;
        bus.op = OP_NONE7;
        #1 chk("nop7_stall", bus.md_stall, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        chk("nop_busy", bus.busy, 0);
        chk("nop_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFA);

        run_md("b2b_1", OP_MULTU, 32'd3, 32'd4, C_MLAT, 64'h00000000_0000000C, 0, a1);
        run_md("b2b_2", OP_MULTU, 32'd5, 32'd6, C_MLAT, 64'h00000000_0000001E, 0, a2);
        chk("b2b_spacing", 64'(a2 - a1), 64'(C_MLAT + 1));

        // Reset in the 3rd busy cycle of a DIV discards it.
        bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid_busy3", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_hilo", {bus.HI, bus.LO}, 64'h0);
        repeat (C_DLAT + 2) @(posedge clk);
        #1;
        chk("rstmid_late_busy", bus.busy, 0);
        chk("rstmid_late_hilo", {bus.HI, bus.LO}, 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal values are WIDTH >= 2.
REQ-002 Parameter MULT_LAT, default 5, busy cycles for MULT/MULTU; legal values are MULT_LAT >= 1.
REQ-003 Parameter DIV_LAT, default 10, busy cycles for DIV/DIVU; legal values are DIV_LAT >= 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  operation request, sampled each edge.
REQ-007 op  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-008 A  input  WIDTH  rs operand.
REQ-009 B  input  WIDTH  rt operand.
REQ-010 busy  output  1  registered; high while a mult/div is in flight.
REQ-011 md_stall  output  1  combinational: busy | (start & op in {MULT,MULTU,DIV,DIVU}).
REQ-012 HI  output  WIDTH  registered HI register.
REQ-013 LO  output  WIDTH  registered LO register.

Function
REQ-014 The block SHALL accept a request only when start=1 and busy=0; requests while busy=1 (any op) SHALL be ignored with no state change.
REQ-015 On an accepted MULT/MULTU/DIV/DIVU at edge k, A, B and op SHALL be latched, and busy SHALL be 1 for cycles k+1 through k+LAT, where LAT = MULT_LAT or DIV_LAT by op.
REQ-016 The down-counter SHALL load LAT-1 at acceptance and decrement each busy cycle; its width SHALL be clog2(max(MULT_LAT,DIV_LAT)+1).
REQ-017 HI/LO SHALL update at the edge that ends the last busy cycle; in that same following cycle busy=0 and the new HI/LO are visible.
REQ-018 A new request SHALL be acceptable in the first cycle with busy=0 (back-to-back spacing LAT+1 cycles).
REQ-019 MULT SHALL form the signed 2*WIDTH product, MULTU the unsigned product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-020 DIV SHALL compute signed division truncated toward zero: LO = quotient, HI = remainder with the sign of the dividend; DIVU unsigned equivalent.
REQ-021 Signed DIV of most-negative value by -1 SHALL give LO = most-negative value, HI = 0.
REQ-022 Division by zero (DIV or DIVU, B=0) SHALL run the full DIV_LAT busy period and leave HI and LO unchanged.
REQ-023 Accepted MTHI/MTLO SHALL write A into HI/LO at the accepting edge, visible the next cycle, busy stays 0.
REQ-024 Operand changes on A/B after acceptance SHALL NOT affect the in-flight result.
REQ-025 op values 000 and 111 with start=1 SHALL be no-ops; md_stall SHALL be 0 for them and for MTHI/MTLO.

Reset
REQ-026 When reset=1 at an edge: busy=0, counter=0, HI=0, LO=0, latched operands cleared; reset SHALL take priority over start.
REQ-027 Reset during an in-flight operation SHALL discard it; no later HI/LO update for that operation.

Verification (WIDTH=32, MULT_LAT=5, DIV_LAT=10)
REQ-028 MULT A=FFFFFFFF B=00000002 -> busy high 5 cycles, then HI=FFFFFFFF LO=FFFFFFFE; MULTU same operands -> HI=00000001 LO=FFFFFFFE.
REQ-029 DIV A=FFFFFFF9 (-7) B=2 -> after 10 busy cycles LO=FFFFFFFD HI=FFFFFFFF; DIVU A=7 B=2 -> LO=3 HI=1; DIV A=80000000 B=FFFFFFFF -> LO=80000000 HI=0.
REQ-030 MTHI A=12345678 then DIVU A=5 B=0 -> HI=12345678 LO unchanged after 10 busy cycles.
REQ-031 MULT accepted, then during busy start MTLO A=AAAAAAAA and DIV -> both ignored, md_stall=1 throughout, only MULT result lands.
REQ-032 DIV accepted, reset asserted in 3rd busy cycle -> next cycle busy=0 HI=LO=0, and values stay 0 past the original completion cycle.
REQ-033 Back-to-back: MULTU 3*4 then MULTU 5*6 presented the first cycle busy=0 -> LO=0000000C then LO=0000001E, spacing exactly 6 cycles between acceptances.
